// File: rtl/sqrt_controller.sv
// Sequencing controller for the iterative square-root unit.
// Resolves special operands directly. Finite positive operands are driven
// through the load, iterate and round phases of the digit-recurrence
// datapath. The result is presented under a valid/ready handshake.
module sqrt_controller #(
  parameter int EXP_SIZE = 11,
  parameter int ITER_S   = 26,
  parameter int ITER_D   = 55,
  parameter int BIAS_S   = 127,
  parameter int BIAS_D   = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                in_ready,
  input  logic                in_type,
  input  logic [2:0]          in_flags,
  input  logic [EXP_SIZE-1:0] in_exp,
  input  logic                sign,
  output logic                dp_load,
  output logic                dp_odd_shift,
  output logic                dp_step,
  output logic                dp_round,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [EXP_SIZE-1:0] out_exp,
  output logic [2:0]          out_flags,
  output logic                out_sign,
  output logic                out_type
);

  localparam int CNT_W = $clog2(ITER_D + 1);

  localparam logic [2:0] FL_FINITE = 3'b100;
  localparam logic [2:0] FL_INF    = 3'b010;
  localparam logic [2:0] FL_NAN    = 3'b001;
  localparam logic [2:0] FL_ZERO   = 3'b000;

  typedef enum logic [2:0] {IDLE, LOAD, ITER, ROUND, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_last;
  logic                cap_type;
  logic [EXP_SIZE-1:0] res_exp;
  logic                is_finite_pos;

  // Result exponent: (biased exponent + bias) / 2. The sum is formed one bit
  // wider so it cannot overflow; the halving brings it back into range.
  function automatic logic [EXP_SIZE-1:0] half_exp(input logic [EXP_SIZE-1:0] e,
                                                   input logic dbl);
    logic [EXP_SIZE:0] b;
    logic [EXP_SIZE:0] s;
    b = dbl ? (EXP_SIZE+1)'(BIAS_D) : (EXP_SIZE+1)'(BIAS_S);
    s = {1'b0, e} + b;
    return s[EXP_SIZE:1];
  endfunction

  // Special-operand result packed as {flags, sign, exponent}.
  // NaN has priority, then zero (keeps its sign), then any negative
  // nonzero operand is invalid, then +inf.
  function automatic logic [EXP_SIZE+3:0] special_res(input logic [2:0] fl,
                                                      input logic sg);
    logic [EXP_SIZE-1:0] ones;
    ones = '1;
    if (fl[0])               return {FL_NAN, 1'b0, ones};
    else if (fl == FL_ZERO)  return {FL_ZERO, sg, {EXP_SIZE{1'b0}}};
    else if (sg)             return {FL_NAN, 1'b0, ones};
    else if (fl[1])          return {FL_INF, 1'b0, ones};
    else                     return {FL_NAN, 1'b0, ones};
  endfunction

  assign is_finite_pos = (in_flags == FL_FINITE) && !sign;
  assign cnt_last      = cap_type ? CNT_W'(ITER_D - 1) : CNT_W'(ITER_S - 1);

  // Controller FSM with registered handshake, datapath strobes and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      dp_load      <= 1'b0;
      dp_odd_shift <= 1'b0;
      dp_step      <= 1'b0;
      dp_round     <= 1'b0;
      out_valid    <= 1'b0;
      out_exp      <= '0;
      out_flags    <= FL_ZERO;
      out_sign     <= 1'b0;
      out_type     <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            in_ready <= 1'b0;
            cap_type <= in_type;
            if (is_finite_pos) begin
              res_exp      <= half_exp(in_exp, in_type);
              // Bias is odd, so an even biased exponent means an odd
              // unbiased exponent that needs the mantissa pre-shift.
              dp_odd_shift <= ~in_exp[0];
              dp_load      <= 1'b1;
              state        <= LOAD;
            end else begin
              {out_flags, out_sign, out_exp} <= special_res(in_flags, sign);
              out_type  <= in_type;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        LOAD: begin
          dp_load      <= 1'b0;
          dp_odd_shift <= 1'b0;
          dp_step      <= 1'b1;
          cnt          <= '0;
          state        <= ITER;
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (cnt == cnt_last) begin
            dp_step  <= 1'b0;
            dp_round <= 1'b1;
            state    <= ROUND;
          end
        end
        ROUND: begin
          dp_round  <= 1'b0;
          out_valid <= 1'b1;
          out_exp   <= res_exp;
          out_flags <= FL_FINITE;
          out_sign  <= 1'b0;
          out_type  <= cap_type;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_controller.sv
// Directed testbench for sqrt_controller: reset, finite single/double
// sequencing, special operands, ignored start, back-to-back handshake and
// mid-operation reset.
module tb_sqrt_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_ready;
  logic        in_type;
  logic [2:0]  in_flags;
  logic [10:0] in_exp;
  logic        sign;
  logic        dp_load;
  logic        dp_odd_shift;
  logic        dp_step;
  logic        dp_round;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_exp;
  logic [2:0]  out_flags;
  logic        out_sign;
  logic        out_type;

  int n_cmp = 0;
  int n_bad = 0;

  sqrt_controller dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .in_type(in_type), .in_flags(in_flags), .in_exp(in_exp), .sign(sign),
    .dp_load(dp_load), .dp_odd_shift(dp_odd_shift), .dp_step(dp_step),
    .dp_round(dp_round), .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_flags(out_flags), .out_sign(out_sign),
    .out_type(out_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [10:0] got;
    rst = 1'b1;
    tick();
    tick();
    got = {in_ready, dp_load, dp_odd_shift, dp_step, dp_round, out_valid, out_sign, out_type, out_flags};
    n_cmp++;
    if (got !== 11'b100_0000_0000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected %b", got, 11'b100_0000_0000);
    end
    n_cmp++;
    if (out_exp !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_exp: got %0d expected 0", out_exp);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({dp_load, dp_step, dp_round, out_valid, in_ready} !== 5'b00001) begin
        n_bad++;
        $display("FAIL idle_quiet cycle %0d: got %b expected 00001", i,
                 {dp_load, dp_step, dp_round, out_valid, in_ready});
      end
    end
  endtask

  // Finite operand through load/iterate/round; optionally pulses a second
  // start during ITER that must be ignored.
  task automatic run_finite(input logic typ, input logic [10:0] e, input logic odd,
                            input logic [10:0] exp_e, input int n, input bit inject,
                            input string name);
    logic [3:0] expv;
    logic [3:0] gotv;
    start = 1'b1; in_type = typ; in_flags = 3'b100; in_exp = e; sign = 1'b0;
    tick();
    start = 1'b0; in_type = ~typ; in_exp = 11'h555; in_flags = 3'b001; sign = 1'b1;
    n_cmp++;
    if ({dp_load, dp_odd_shift, dp_step, dp_round, out_valid, in_ready} !== {1'b1, odd, 4'b0000}) begin
      n_bad++;
      $display("FAIL %s_load: got %b expected %b", name,
               {dp_load, dp_odd_shift, dp_step, dp_round, out_valid, in_ready}, {1'b1, odd, 4'b0000});
    end
    for (int c = 2; c <= n + 3; c++) begin
      if (inject && c == 6) begin
        start = 1'b1; in_type = ~typ; in_flags = 3'b100; in_exp = 11'd300; sign = 1'b0;
      end
      tick();
      start = 1'b0;
      expv = {1'b0, (c <= n + 1), (c == n + 2), (c == n + 3)};
      gotv = {dp_load, dp_step, dp_round, out_valid};
      n_cmp++;
      if (gotv !== expv) begin
        n_bad++;
        $display("FAIL %s_seq cycle %0d: got %b expected %b", name, c, gotv, expv);
      end
    end
    n_cmp++;
    if ({out_exp, out_flags, out_sign, out_type, in_ready} !== {exp_e, 3'b100, 1'b0, typ, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_result: got exp %0d flags %b sign %b type %b rdy %b expected exp %0d flags 100 sign 0 type %b rdy 0",
               name, out_exp, out_flags, out_sign, out_type, in_ready, exp_e, typ);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({out_valid, out_exp, out_flags, dp_step} !== {1'b1, exp_e, 3'b100, 1'b0}) begin
        n_bad++;
        $display("FAIL %s_hold cycle %0d: got valid %b exp %0d flags %b expected valid 1 exp %0d flags 100",
                 name, i, out_valid, out_exp, out_flags, exp_e);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, out_exp} !== {1'b1, 1'b0, exp_e}) begin
      n_bad++;
      $display("FAIL %s_handshake: got rdy %b valid %b exp %0d expected rdy 1 valid 0 exp %0d",
               name, in_ready, out_valid, out_exp, exp_e);
    end
  endtask

  task automatic run_special(input logic [2:0] fl, input logic sg, input logic typ,
                             input logic [2:0] efl, input logic esg, input logic [10:0] eexp,
                             input string name);
    start = 1'b1; in_type = typ; in_flags = fl; in_exp = 11'd1000; sign = sg;
    tick();
    start = 1'b0; in_flags = 3'b100; sign = ~sg;
    n_cmp++;
    if ({dp_load, dp_odd_shift, dp_step, dp_round, out_valid, in_ready} !== 6'b000010) begin
      n_bad++;
      $display("FAIL %s_ctrl: got %b expected 000010", name,
               {dp_load, dp_odd_shift, dp_step, dp_round, out_valid, in_ready});
    end
    n_cmp++;
    if ({out_flags, out_sign, out_exp, out_type} !== {efl, esg, eexp, typ}) begin
      n_bad++;
      $display("FAIL %s_result: got flags %b sign %b exp %0d type %b expected flags %b sign %b exp %0d type %b",
               name, out_flags, out_sign, out_exp, out_type, efl, esg, eexp, typ);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, dp_load, dp_step, dp_round} !== 5'b10000) begin
      n_bad++;
      $display("FAIL %s_handshake: got %b expected 10000", name,
               {in_ready, out_valid, dp_load, dp_step, dp_round});
    end
  endtask

  task automatic test_specials();
    run_special(3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 11'd0,     "neg_zero");
    run_special(3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 11'h7FF,   "pos_inf");
    run_special(3'b100, 1'b1, 1'b0, 3'b001, 1'b0, 11'h7FF,   "neg_finite");
    run_special(3'b001, 1'b1, 1'b1, 3'b001, 1'b0, 11'h7FF,   "nan");
    run_special(3'b010, 1'b1, 1'b0, 3'b001, 1'b0, 11'h7FF,   "neg_inf");
    run_special(3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 11'd0,     "pos_zero");
  endtask

  task automatic test_back_to_back();
    start = 1'b1; in_type = 1'b0; in_flags = 3'b010; in_exp = 11'd5; sign = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_no_same_cycle: got %b expected 10", {in_ready, out_valid});
    end
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, out_flags} !== 5'b01010) begin
      n_bad++;
      $display("FAIL b2b_second_accept: got %b expected 01010", {in_ready, out_valid, out_flags});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_release: got %b expected 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    start = 1'b1; in_type = 1'b1; in_flags = 3'b100; in_exp = 11'd1024; sign = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 21; c++) tick();
    n_cmp++;
    if (dp_step !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_step20: got dp_step %b expected 1", dp_step);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, dp_step, dp_round, out_valid, out_exp} !== {4'b1000, 11'd0}) begin
      n_bad++;
      $display("FAIL mid_reset: got rdy %b step %b round %b valid %b exp %0d expected 1 0 0 0 0",
               in_ready, dp_step, dp_round, out_valid, out_exp);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid !== 1'b0 || dp_step !== 1'b0) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid) begin
      n_bad++;
      $display("FAIL mid_no_valid: got activity after reset expected none");
    end
    run_finite(1'b0, 11'd127, 1'b0, 11'd127, 26, 1'b0, "after_rst");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_type = 1'b0; in_flags = 3'b000;
    in_exp = 11'd0; sign = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    run_finite(1'b1, 11'd1024, 1'b1, 11'd1023, 55, 1'b0, "double");
    run_finite(1'b0, 11'd127,  1'b0, 11'd127,  26, 1'b0, "single");
    run_finite(1'b0, 11'd130,  1'b1, 11'd128,  26, 1'b0, "single_even");
    test_specials();
    run_finite(1'b1, 11'd1030, 1'b1, 11'd1026, 55, 1'b1, "ignore_start");
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sqrt_controller.md
# sqrt_controller

Sequencing FSM for the iterative square-root unit of the FPU. Accepts one operand per start/in_ready handshake from the input wrapper stage, resolves special operands (zero, infinity, NaN, negative) without touching the datapath, otherwise drives the digit-recurrence datapath through load, iterate and round phases. Computes the result exponent and presents the result under a valid/ready handshake to the FPU output stage.

## Interface

- EXP_SIZE, 11, exponent width
- ITER_S, 26, datapath iterations for single precision
- ITER_D, 55, datapath iterations for double precision
- BIAS_S, 127, single-precision exponent bias
- BIAS_D, 1023, double-precision exponent bias

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  operand valid; accepted only when in_ready=1
- in_ready  output  1  controller idle, can accept an operand
- in_type  input  1  0 = single, 1 = double
- in_flags  input  3  class: 100 finite nonzero, 010 infinity, 001 NaN, 000 zero
- in_exp  input  EXP_SIZE  biased operand exponent
- sign  input  1  operand sign
- dp_load  output  1  one-cycle pulse: datapath loads operand and clears remainder/root
- dp_odd_shift  output  1  datapath pre-shifts mantissa left by 1 on load; valid with dp_load
- dp_step  output  1  datapath performs one recurrence iteration this cycle
- dp_round  output  1  one-cycle pulse: datapath rounds/normalizes the root
- out_valid  output  1  result valid; held until out_ready
- out_ready  input  1  downstream accepts result
- out_exp  output  EXP_SIZE  result biased exponent
- out_flags  output  3  result class, same encoding as in_flags
- out_sign  output  1  result sign
- out_type  output  1  captured in_type

## Operation

- States: IDLE, LOAD, ITER, ROUND, DONE.
- IDLE: in_ready=1. On start=1, capture in_type, in_flags, in_exp, sign. Finite nonzero positive -> LOAD; otherwise -> DONE with special result.
- Special results (no dp_* activity): NaN in -> 001, sign 0; zero -> 000, sign = input sign (sqrt(-0) = -0); +inf -> 010, sign 0; sign=1 with flags 100 or 010 -> 001 (invalid), sign 0. out_exp: 0 for zero, all ones for inf/NaN.
- Exponent (finite case): B = in_type ? BIAS_D : BIAS_S; out_exp = (in_exp + B) >> 1, sum computed at EXP_SIZE+1 bits, no overflow possible. dp_odd_shift = ~in_exp[0] (unbiased exponent odd because B odd).
- LOAD: dp_load=1 for one cycle, iteration counter cleared -> ITER.
- ITER: dp_step=1 each cycle; counter increments; after N cycles (N = in_type ? ITER_D : ITER_S) -> ROUND. Counter width ceil(log2(ITER_D+1)).
- ROUND: dp_round=1 for one cycle, out_flags=100, out_sign=0 -> DONE.
- DONE: out_valid=1, outputs stable; on out_ready=1 -> IDLE. out_ready while out_valid=0 is ignored.
- start while in_ready=0 is ignored and not queued; input buses may change freely after acceptance.
- At most one of dp_load, dp_step, dp_round high in any cycle.

## Timing

- Reset: state IDLE; in_ready=1; dp_load, dp_odd_shift, dp_step, dp_round, out_valid=0; out_exp=0, out_flags=000, out_sign=0, out_type=0, counter 0.
- rst mid-operation (any state) returns to reset values next edge; partial result discarded, no out_valid.
- Finite operand accepted at edge 0: dp_load cycle 1, dp_step cycles 2..N+1, dp_round cycle N+2, out_valid from cycle N+3. Latency N+3 (29 single, 58 double).
- Special operand accepted at edge 0: out_valid from cycle 1.
- out_valid and out_ready both high at edge k: in_ready=1 in cycle k+1; earliest next accept edge k+1. No same-cycle accept during DONE.
- Outputs registered; out_* change only on entry to DONE (or reset).

## Test plan

- Reset then idle: rst=1 two cycles -> all outputs at reset values, in_ready=1; release, no start -> dp_* stay 0.
- Double, in_exp=1024, flags 100, sign 0 -> dp_load cycle 1 with dp_odd_shift=1, 55 dp_step cycles, dp_round cycle 57, out_valid cycle 58, out_exp=1023, out_flags=100.
- Single, in_exp=127 -> dp_odd_shift=0, 26 steps, out_valid cycle 29, out_exp=127; hold out_ready=0 10 cycles -> outputs stable; out_ready=1 -> in_ready next cycle.
- Specials: flags 000 sign 1 -> out_valid cycle 1, out_flags=000, out_sign=1; flags 010 sign 0 -> 010; flags 100 sign 1 -> 001; flags 001 -> 001; dp_* never asserted.
- start pulsed during ITER with different operand -> ignored; result matches first operand.
- rst asserted at step 20 of double -> IDLE next cycle, out_valid never rises; new single operand completes normally in 29 cycles.
